// File: rtl/ifetch_seq32.sv
// Multi-cycle instruction fetch stage: owns the PC, fetches over a req/valid handshake with retry,
// and commits the next PC on exec_done. Optional feature macro: MISALIGN_TRAP_EN.
module ifetch_seq32 #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        Jr,
    input  logic        Jmp,
    input  logic        Jal,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Zero,
    input  logic [31:0] Read_data_1,
    output logic [31:0] pc,
    output logic [31:0] branch_base_addr,
    output logic [31:0] link_addr,
    output logic        misalign_trap
);

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StReq, StWait, StExec, StTrap} state_e;
`else
    typedef enum logic [1:0] {StReq, StWait, StExec} state_e;
`endif

    localparam logic [7:0] WaitLast = 8'(MAX_WAIT - 1);

    state_e      state_q, state_d;
    logic [31:0] pc_q, instr_q, link_q;
    logic [7:0]  wait_cnt_q;
    logic [31:0] pc4, jump_target, br_target, next_pc;
    logic        br_taken, commit, wait_expired;

    assign pc4          = pc_q + 32'd4;
    assign jump_target  = {pc4[31:28], instr_q[25:0], 2'b00};
    assign br_target    = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign br_taken     = (Branch && Zero) || (nBranch && !Zero);
    assign commit       = (state_q == StExec) && exec_done;
    assign wait_expired = (wait_cnt_q == WaitLast);

    always_comb begin
        if (Jr) begin
            next_pc = Read_data_1;
        end else if (Jmp || Jal) begin
            next_pc = jump_target;
        end else if (br_taken) begin
            next_pc = br_target;
        end else begin
            next_pc = pc4;
        end
    end

    // State register; reset forces REQ from any state, abandoning outstanding responses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq:  state_d = StWait;
            StWait: begin
                if (imem_valid) begin
                    state_d = StExec;
                end else if (wait_expired) begin
                    state_d = StReq;
                end
            end
            StExec: begin
                if (exec_done) begin
`ifdef MISALIGN_TRAP_EN
                    state_d = (next_pc[1:0] != 2'b00) ? StTrap : StReq;
`else
                    state_d = StReq;
`endif
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        imem_req      = reset && (state_q == StReq);
        instr_valid   = (state_q == StExec);
`ifdef MISALIGN_TRAP_EN
        misalign_trap = (state_q == StTrap);
`else
        misalign_trap = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            link_q     <= 32'h0;
            wait_cnt_q <= 8'h0;
        end else begin
            if (state_q == StReq) begin
                wait_cnt_q <= 8'h0;
            end else if (state_q == StWait && !imem_valid && !wait_expired) begin
                wait_cnt_q <= wait_cnt_q + 8'd1;
            end
            if (state_q == StWait && imem_valid) begin
                instr_q <= imem_rdata;
            end
            if (commit && Jal) begin
                link_q <= pc4;
            end
            if (commit) begin
`ifdef MISALIGN_TRAP_EN
                if (next_pc[1:0] == 2'b00) begin
                    pc_q <= next_pc;
                end
`else
                pc_q <= {next_pc[31:2], 2'b00};
`endif
            end
        end
    end

    assign pc               = pc_q;
    assign imem_addr        = pc_q;
    assign instruction      = instr_q;
    assign link_addr        = link_q;
    assign branch_base_addr = pc4;

endmodule

// File: doc/ifetch_seq32.md
Name: ifetch_seq32

Overview:
- Multi-cycle instruction fetch stage directly upstream of the main decoder/control unit.
- Owns the PC and fetches each instruction word from instruction memory over a req/valid handshake with bounded retry.
- Holds the instruction stable for decode and execute.
- On `exec_done`, computes the next PC from the decoder's Jr/Jmp/Jal/Branch/nBranch strobes and the ALU `Zero` flag, and produces the link address for Jal.

Parameters:
- `RESET_PC`, 32'h0000_0000, byte address loaded into PC on reset.
- `MAX_WAIT`, 15, cycles spent in WAIT without `imem_valid` before the request is re-issued (range 1..255).

Ports:
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low (reset==0 resets on the next rising edge).
- `imem_req` output 1: one-cycle fetch request strobe.
- `imem_addr` output 32: byte address of the fetch; equals `pc`.
- `imem_rdata` input 32: instruction word returned by memory.
- `imem_valid` input 1: `imem_rdata` valid this cycle.
- `instruction` output 32: latched instruction for decode (opcode = [31:26], funct = [5:0]).
- `instr_valid` output 1: high while `instruction` is valid (EXEC state).
- `exec_done` input 1: datapath finished the current instruction; commit next PC.
- `Jr`, `Jmp`, `Jal`, `Branch`, `nBranch` input 1 each: decoder strobes for the current instruction.
- `Zero` input 1: ALU equality result.
- `Read_data_1` input 32: rs value, used as the Jr target.
- `pc` output 32: current PC.
- `branch_base_addr` output 32: pc+4 (combinational).
- `link_addr` output 32: return address registered on Jal commit.
- `misalign_trap` output 1: see Optional Feature.

Behaviour:
- Reset (reset==0 at an edge) sets:
  - state=REQ, pc=RESET_PC, instruction=0, link_addr=0, wait_cnt=0, misalign_trap=0.
  - Reset can occur in any state. Any outstanding memory response is abandoned, and any `imem_valid` seen in REQ is ignored.
- Outputs by state (combinational): `imem_req`=1 only in REQ; `instr_valid`=1 only in EXEC.
  - While reset is asserted, the state is still forced to REQ at each edge, but `imem_req` is gated to 0.
- State REQ:
  - `imem_req`=1 for exactly one cycle, `imem_addr`=pc.
  - Next state is WAIT unconditionally; wait_cnt cleared.
- State WAIT:
  - If `imem_valid`=1: instruction<=`imem_rdata`, next state EXEC. Minimum fetch latency is REQ, then WAIT with valid, then EXEC on the 3rd cycle.
  - Else if wait_cnt==MAX_WAIT-1: next state REQ (retry the same pc).
  - Otherwise wait_cnt increments.
- State EXEC:
  - `instruction` is held stable.
  - `exec_done`=0: remain in EXEC indefinitely.
  - `exec_done`=1: pc<=next_pc, next state REQ.
  - `exec_done` is ignored in REQ and WAIT.
  - `imem_valid` is ignored outside WAIT.
- next_pc priority, highest first:
  1. Jr: `Read_data_1`.
  2. Jmp or Jal: {pc4[31:28], instruction[25:0], 2'b00}.
  3. Branch && Zero, or nBranch && !Zero: pc4 + (sign-extended instruction[15:0] << 2).
  4. Otherwise: pc4.
  - pc4 = pc+4.
  - All adds are 32-bit modulo 2^32; wrap at 0xFFFF_FFFC to 0 is legal.
- `link_addr` <= pc4 when `exec_done` && Jal; otherwise it holds its value.
- Simultaneous strobes resolve by the priority above. Jal always writes `link_addr` even if Jr is also set.

Optional Feature:
- Macro: `MISALIGN_TRAP_EN`.
- Defined:
  - If the selected next_pc[1:0] != 0 on commit, pc is not updated and the block enters state TRAP.
  - TRAP: `misalign_trap`=1, `imem_req`=0, `instr_valid`=0, all inputs ignored.
  - TRAP is left only via reset.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 before loading pc.
  - `misalign_trap` is tied to 0 and TRAP does not exist.

Test Plan:
- Reset with RESET_PC=0, release, memory returns 0x2008_0005 one cycle after req → `imem_req` pulses at pc=0, `instr_valid`=1 on the 3rd cycle, `instruction`=0x2008_0005; `exec_done` → pc=4.
- pc=0x10, instruction 0x1000_FFFF (beq, imm=-1), Branch=1, Zero=1, `exec_done` → pc=0x10. Repeat with Zero=0 → pc=0x14.
- pc=0x0040_0008, instruction 0x0C00_0040, Jal=1 → pc=0x0000_0100, `link_addr`=0x0040_000C. Then Jr=1, `Read_data_1`=0x0040_000C → pc=0x0040_000C.
- MAX_WAIT=4, `imem_valid` withheld → `imem_req` re-pulses at the same address every 5 cycles; valid on the 2nd attempt → EXEC with that word.
- Reset asserted in WAIT, then `imem_valid` arrives during reset → ignored; after release, `imem_req` at RESET_PC.
- `MISALIGN_TRAP_EN` defined, Jr with `Read_data_1`=0x0000_0102 → `misalign_trap`=1, pc unchanged, no further req until reset. Without the macro → pc=0x0000_0100.
